// File: rtl/hx8357_controller.sv
// hx8357_controller
// Write-only 16-bit 8080-style bus controller for an HX8357 TFT driver.
// After reset it drives the display hardware-reset sequence (RESx low, then
// a settle wait). It then turns level-sensitive cmd/data requests into single
// CSx/DCx/WRx write cycles and pulses transmission_cmpl at the end of each.
//
// Ports:
//   clk               system clock, rising edge
//   nres              asynchronous active-low reset
//   data_in[15:0]     command code / data word, sampled when a write starts
//   cmd               level request: write data_in as command (DCx=0)
//   data              level request: write data_in as data (DCx=1)
//   transmission_cmpl one-cycle pulse when a write finishes
//   CSx, RESx, DCx, WRx, RDx, DATAx[15:0]  registered display pins
module hx8357_controller #(
  parameter int unsigned RST_LOW_CYCLES  = 250,
  parameter int unsigned RST_WAIT_CYCLES = 3_000_000
) (
  input  logic        clk,
  input  logic        nres,
  input  logic [15:0] data_in,
  input  logic        cmd,
  input  logic        data,
  output logic        transmission_cmpl,
  output logic        CSx,
  output logic        RESx,
  output logic        DCx,
  output logic        WRx,
  output logic        RDx,
  output logic [15:0] DATAx
);

  localparam int unsigned CNT_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ?
                                    RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_RST_LOW  = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETUP    = 3'd3,
    ST_WR_LOW   = 3'd4,
    ST_WR_HIGH  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cs_q, cs_d;
  logic               res_q, res_d;
  logic               dc_q, dc_d;
  logic               wr_q, wr_d;
  logic               cmpl_q, cmpl_d;
  logic [15:0]        dat_q, dat_d;
  logic               rd_q;

  // Every output is a flop whose next value is decided together with the
  // state transition, so pin changes line up exactly with state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    res_d   = res_q;
    dc_d    = dc_q;
    wr_d    = wr_q;
    cmpl_d  = 1'b0;
    dat_d   = dat_q;

    unique case (state_q)
      ST_RST_LOW: begin
        res_d = 1'b0;
        if (cnt_q == CNT_W'(RST_LOW_CYCLES - 1)) begin
          state_d = ST_RST_WAIT;
          res_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        cs_d = 1'b1;
        wr_d = 1'b1;
        // cmd wins when both requests are high
        if (cmd || data) begin
          state_d = ST_SETUP;
          dc_d    = ~cmd;
          dat_d   = data_in;
          cs_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_SETUP: begin
        state_d = ST_WR_LOW;
        wr_d    = 1'b0;
        cnt_d   = '0;
      end

      ST_WR_LOW: begin
        state_d = ST_WR_HIGH;
        wr_d    = 1'b1;
        cnt_d   = '0;
      end

      ST_WR_HIGH: begin
        state_d = ST_DONE;
        cs_d    = 1'b1;
        cmpl_d  = 1'b1;
        cnt_d   = '0;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_RST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q <= ST_RST_LOW;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      res_q   <= 1'b0;
      dc_q    <= 1'b1;
      wr_q    <= 1'b1;
      cmpl_q  <= 1'b0;
      dat_q   <= '0;
      rd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      res_q   <= res_d;
      dc_q    <= dc_d;
      wr_q    <= wr_d;
      cmpl_q  <= cmpl_d;
      dat_q   <= dat_d;
      rd_q    <= 1'b1;
    end
  end

  assign transmission_cmpl = cmpl_q;
  assign CSx               = cs_q;
  assign RESx              = res_q;
  assign DCx               = dc_q;
  assign WRx               = wr_q;
  assign RDx               = rd_q;
  assign DATAx             = dat_q;

endmodule

// File: tb/tb_hx8357_controller.sv
module tb_hx8357_controller;

  logic        clk = 1'b0;
  logic        nres = 1'b0;
  logic        cmd = 1'b0;
  logic        data = 1'b0;
  logic [15:0] data_in = '0;
  logic        transmission_cmpl, CSx, RESx, DCx, WRx, RDx;
  logic [15:0] DATAx;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  // values on the bus at each WRx rising edge, plus edge counts
  logic [15:0] cap_dat [0:15];
  logic        cap_dc  [0:15];
  int unsigned wr_rise = 0;
  int unsigned wr_fall = 0;

  hx8357_controller #(
    .RST_LOW_CYCLES (4),
    .RST_WAIT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .nres             (nres),
    .data_in          (data_in),
    .cmd              (cmd),
    .data             (data),
    .transmission_cmpl(transmission_cmpl),
    .CSx              (CSx),
    .RESx             (RESx),
    .DCx              (DCx),
    .WRx              (WRx),
    .RDx              (RDx),
    .DATAx            (DATAx)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge WRx) begin
    cap_dat[wr_rise % 16] = DATAx;
    cap_dc[wr_rise % 16]  = DCx;
    wr_rise++;
  end
  always @(negedge WRx) wr_fall++;

  task automatic test_reset();
    nres = 1'b0; cmd = 1'b0; data = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (CSx !== 1'b1) begin n_fail++; $display("FAIL reset_CSx: got %b expected 1", CSx); end
    n_checks++; if (RESx !== 1'b0) begin n_fail++; $display("FAIL reset_RESx: got %b expected 0", RESx); end
    n_checks++; if (DCx !== 1'b1) begin n_fail++; $display("FAIL reset_DCx: got %b expected 1", DCx); end
    n_checks++; if (WRx !== 1'b1) begin n_fail++; $display("FAIL reset_WRx: got %b expected 1", WRx); end
    n_checks++; if (RDx !== 1'b1) begin n_fail++; $display("FAIL reset_RDx: got %b expected 1", RDx); end
    n_checks++; if (DATAx !== 16'h0000) begin n_fail++; $display("FAIL reset_DATAx: got %h expected 0000", DATAx); end
    n_checks++; if (transmission_cmpl !== 1'b0) begin n_fail++; $display("FAIL reset_cmpl: got %b expected 0", transmission_cmpl); end
    nres = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (RESx !== ((i == 4) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL reset_RESx_edge%0d: got %b expected %b", i, RESx, (i == 4));
      end
    end
    // request raised during the wait must be held off until IDLE
    cmd = 1'b1; data_in = 16'h0080;
    for (int i = 5; i <= 12; i++) begin
      @(negedge clk);
      n_checks++; if (CSx !== 1'b1) begin n_fail++; $display("FAIL reset_wait_CSx_edge%0d: got %b expected 1", i, CSx); end
    end
  endtask

  task automatic test_cmd();
    int unsigned base_f, base_r;
    base_f = wr_fall; base_r = wr_rise;
    @(negedge clk);  // SETUP
    n_checks++; if (CSx !== 1'b0) begin n_fail++; $display("FAIL cmd_setup_CSx: got %b expected 0", CSx); end
    n_checks++; if (DCx !== 1'b0) begin n_fail++; $display("FAIL cmd_setup_DCx: got %b expected 0", DCx); end
    n_checks++; if (DATAx !== 16'h0080) begin n_fail++; $display("FAIL cmd_setup_DATAx: got %h expected 0080", DATAx); end
    n_checks++; if (WRx !== 1'b1) begin n_fail++; $display("FAIL cmd_setup_WRx: got %b expected 1", WRx); end
    data_in = 16'hFFFF;
    @(negedge clk);  // WR_LOW
    n_checks++; if (WRx !== 1'b0) begin n_fail++; $display("FAIL cmd_wrlow_WRx: got %b expected 0", WRx); end
    n_checks++; if (CSx !== 1'b0) begin n_fail++; $display("FAIL cmd_wrlow_CSx: got %b expected 0", CSx); end
    n_checks++; if (DATAx !== 16'h0080) begin n_fail++; $display("FAIL cmd_wrlow_DATAx: got %h expected 0080", DATAx); end
    @(negedge clk);  // WR_HIGH
    n_checks++; if (WRx !== 1'b1) begin n_fail++; $display("FAIL cmd_wrhigh_WRx: got %b expected 1", WRx); end
    n_checks++; if (CSx !== 1'b0) begin n_fail++; $display("FAIL cmd_wrhigh_CSx: got %b expected 0", CSx); end
    n_checks++; if (transmission_cmpl !== 1'b0) begin n_fail++; $display("FAIL cmd_wrhigh_cmpl: got %b expected 0", transmission_cmpl); end
    @(negedge clk);  // DONE
    n_checks++; if (transmission_cmpl !== 1'b1) begin n_fail++; $display("FAIL cmd_done_cmpl: got %b expected 1", transmission_cmpl); end
    n_checks++; if (CSx !== 1'b1) begin n_fail++; $display("FAIL cmd_done_CSx: got %b expected 1", CSx); end
    cmd = 1'b0;
    @(negedge clk);  // IDLE
    n_checks++; if (transmission_cmpl !== 1'b0) begin n_fail++; $display("FAIL cmd_idle_cmpl: got %b expected 0", transmission_cmpl); end
    repeat (3) @(negedge clk);
    n_checks++; if (wr_fall - base_f !== 1) begin n_fail++; $display("FAIL cmd_wr_pulses: got %0d expected 1", wr_fall - base_f); end
    n_checks++; if (cap_dat[base_r % 16] !== 16'h0080) begin n_fail++; $display("FAIL cmd_latched_data: got %h expected 0080", cap_dat[base_r % 16]); end
    n_checks++; if (cap_dc[base_r % 16] !== 1'b0) begin n_fail++; $display("FAIL cmd_latched_dc: got %b expected 0", cap_dc[base_r % 16]); end
  endtask

  task automatic test_data_seq();
    int unsigned base_f, base_r;
    bit got;
    base_f = wr_fall; base_r = wr_rise;
    data = 1'b1; data_in = 16'h1234;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin @(negedge clk); if (transmission_cmpl === 1'b1) got = 1; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL data_first_cmpl: got timeout expected pulse"); end
    data_in = 16'h5678;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin @(negedge clk); if (transmission_cmpl === 1'b1) got = 1; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL data_second_cmpl: got timeout expected pulse"); end
    data = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (wr_fall - base_f !== 2) begin n_fail++; $display("FAIL data_wr_pulses: got %0d expected 2", wr_fall - base_f); end
    n_checks++; if (cap_dat[base_r % 16] !== 16'h1234) begin n_fail++; $display("FAIL data_word0: got %h expected 1234", cap_dat[base_r % 16]); end
    n_checks++; if (cap_dc[base_r % 16] !== 1'b1) begin n_fail++; $display("FAIL data_dc0: got %b expected 1", cap_dc[base_r % 16]); end
    n_checks++; if (cap_dat[(base_r + 1) % 16] !== 16'h5678) begin n_fail++; $display("FAIL data_word1: got %h expected 5678", cap_dat[(base_r + 1) % 16]); end
    n_checks++; if (cap_dc[(base_r + 1) % 16] !== 1'b1) begin n_fail++; $display("FAIL data_dc1: got %b expected 1", cap_dc[(base_r + 1) % 16]); end
  endtask

  task automatic test_priority();
    int unsigned base_r;
    bit got;
    base_r = wr_rise;
    cmd = 1'b1; data = 1'b1; data_in = 16'h002A;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin @(negedge clk); if (transmission_cmpl === 1'b1) got = 1; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL prio_cmpl: got timeout expected pulse"); end
    cmd = 1'b0; data = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_rise - base_r !== 1) begin n_fail++; $display("FAIL prio_wr_pulses: got %0d expected 1", wr_rise - base_r); end
    n_checks++; if (cap_dc[base_r % 16] !== 1'b0) begin n_fail++; $display("FAIL prio_dc: got %b expected 0", cap_dc[base_r % 16]); end
    n_checks++; if (cap_dat[base_r % 16] !== 16'h002A) begin n_fail++; $display("FAIL prio_data: got %h expected 002a", cap_dat[base_r % 16]); end
  endtask

  task automatic test_back_to_back();
    int unsigned base_f, n, rd_bad;
    int unsigned t [0:2];
    base_f = wr_fall; n = 0; rd_bad = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    data = 1'b1; data_in = 16'hABCD;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (RDx !== 1'b1) rd_bad++;
      if (transmission_cmpl === 1'b1) begin
        t[n] = cyc; n++;
        if (n == 3) data = 1'b0;
      end
    end
    repeat (10) begin @(negedge clk); if (RDx !== 1'b1) rd_bad++; end
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL b2b_cmpl_count: got %0d expected 3", n); end
    n_checks++; if (t[1] - t[0] !== 5) begin n_fail++; $display("FAIL b2b_gap0: got %0d expected 5", t[1] - t[0]); end
    n_checks++; if (t[2] - t[1] !== 5) begin n_fail++; $display("FAIL b2b_gap1: got %0d expected 5", t[2] - t[1]); end
    n_checks++; if (wr_fall - base_f !== 3) begin n_fail++; $display("FAIL b2b_wr_pulses: got %0d expected 3", wr_fall - base_f); end
    n_checks++; if (rd_bad !== 0) begin n_fail++; $display("FAIL b2b_RDx: got %0d cycles low expected 0", rd_bad); end
  endtask

  task automatic test_nres_abort();
    bit got;
    int unsigned cmpl_seen;
    data = 1'b1; data_in = 16'h1111;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin @(negedge clk); if (WRx === 1'b0) got = 1; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL abort_wrlow: got timeout expected WRx low"); end
    #1 nres = 1'b0;
    #1;
    n_checks++; if (WRx !== 1'b1) begin n_fail++; $display("FAIL abort_WRx: got %b expected 1", WRx); end
    n_checks++; if (CSx !== 1'b1) begin n_fail++; $display("FAIL abort_CSx: got %b expected 1", CSx); end
    n_checks++; if (RESx !== 1'b0) begin n_fail++; $display("FAIL abort_RESx: got %b expected 0", RESx); end
    n_checks++; if (DATAx !== 16'h0000) begin n_fail++; $display("FAIL abort_DATAx: got %h expected 0000", DATAx); end
    n_checks++; if (DCx !== 1'b1) begin n_fail++; $display("FAIL abort_DCx: got %b expected 1", DCx); end
    data = 1'b0;
    cmpl_seen = (transmission_cmpl === 1'b1) ? 1 : 0;
    repeat (4) begin @(negedge clk); if (transmission_cmpl === 1'b1) cmpl_seen++; end
    nres = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (transmission_cmpl === 1'b1) cmpl_seen++;
      n_checks++;
      if (RESx !== ((i == 4) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL abort_restart_RESx_edge%0d: got %b expected %b", i, RESx, (i == 4));
      end
    end
    repeat (10) begin @(negedge clk); if (transmission_cmpl === 1'b1) cmpl_seen++; end
    n_checks++; if (cmpl_seen !== 0) begin n_fail++; $display("FAIL abort_cmpl: got %0d pulses expected 0", cmpl_seen); end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_data_seq();
    test_priority();
    test_back_to_back();
    test_nres_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hx8357_controller.md
# hx8357_controller

Write-only 8080-style parallel (16-bit) interface controller for an HX8357 TFT display driver. It generates the display hardware-reset sequence after system reset. It then converts level-sensitive command/data write requests from upstream control logic into single CSx/DCx/WRx bus cycles, and pulses `transmission_cmpl` when each cycle finishes. It sits between the display-content FSM and the display pins.

## Interface
- `RST_LOW_CYCLES`, default 250: clocks RESx is held low after reset (10 µs at 25 MHz).
- `RST_WAIT_CYCLES`, default 3_000_000: clocks after RESx rises before the first request is accepted (120 ms at 25 MHz).
- `clk` in 1: system clock, 25 MHz nominal; all logic on the rising edge.
- `nres` in 1: reset, asynchronous, active-low.
- `data_in` in 16: command code or data word; sampled at transaction start.
- `cmd` in 1: level request to write `data_in` as a command (DCx=0).
- `data` in 1: level request to write `data_in` as data/parameter (DCx=1).
- `transmission_cmpl` out 1: one-cycle pulse at the end of each write.
- `CSx` out 1: chip select, active-low.
- `RESx` out 1: display hardware reset, active-low.
- `DCx` out 1: 0 = command, 1 = data.
- `WRx` out 1: write strobe, active-low; the display latches on the rising edge.
- `RDx` out 1: read strobe; tied high, because reads are not supported.
- `DATAx` out 16: parallel data bus; always driven, never tri-stated.

## Operation
- All outputs are registered.
- Values while `nres`=0: CSx=1, RESx=0, DCx=1, WRx=1, RDx=1, DATAx=0, transmission_cmpl=0, state=RST_LOW, counter=0.
- States:
  - RST_LOW: RESx=0. Counts RST_LOW_CYCLES, then goes to RST_WAIT.
  - RST_WAIT: RESx=1. Counts RST_WAIT_CYCLES, then goes to IDLE.
  - IDLE: CSx=1, WRx=1. Samples requests. If cmd=1, go to SETUP with DCx←0. Otherwise, if data=1, go to SETUP with DCx←1. In both cases DATAx←data_in and CSx←0. cmd has priority when both are high. With no request, stay in IDLE.
  - SETUP: CSx=0, WRx=1, DATAx/DCx stable. Go to WR_LOW.
  - WR_LOW: WRx←0. Go to WR_HIGH.
  - WR_HIGH: WRx←1 (latch edge). Go to DONE.
  - DONE: CSx←1, transmission_cmpl←1 for this cycle only. Go to IDLE.
- DATAx and DCx hold their last values in IDLE. After reset they read 0 and 1 respectively.
- Requests are level-sensitive.
  - A request still high in IDLE after DONE starts a new transaction with the current data_in.
  - Upstream must drop or change the request in the same cycle it sees transmission_cmpl.
  - Requests asserted during RST_LOW/RST_WAIT are not lost. They are served once IDLE is reached, provided they are still held.
- data_in changes during a transaction have no effect.
- `nres` asserted mid-transaction aborts it immediately: all outputs go to their reset values and the init sequence restarts.
- The counter is wide enough for the larger of the two reset parameters (22 bits at the defaults). It is cleared on every state change.

## Timing
- Request sampled in IDLE at edge k:
  - SETUP outputs valid after k.
  - WRx low after k+1.
  - WRx high after k+2.
  - DONE (cmpl=1, CSx=1) after k+3.
  - IDLE after k+4.
- Each transaction takes 5 clocks, IDLE included. Back-to-back throughput is one word per 5 clocks (200 ns at 25 MHz).
- WRx low width: 1 clock (40 ns).
- Data setup to WRx rise: 2 clocks. Hold after WRx rise: ≥1 clock.
- CSx is low for SETUP, WR_LOW and WR_HIGH (3 clocks).
- First IDLE occurs RST_LOW_CYCLES + RST_WAIT_CYCLES clocks after nres deasserts, ±1.

## Test plan
- Reset (parameters overridden to RST_LOW_CYCLES=4, RST_WAIT_CYCLES=8) -> during nres=0 outputs are CSx=1, RESx=0, DCx=1, WRx=1, RDx=1, DATAx=0, cmpl=0; after release, RESx stays low 4 clocks, then high; first request is accepted only after the 8-clock wait.
- cmd=1, data_in=0x0080 -> one bus cycle: CSx low 3 clocks, DCx=0, DATAx=0x0080, WRx low exactly 1 clock. cmpl pulses once, CSx=1 in that cycle.
- Drop cmd on cmpl, then data=1 with 0x1234, then 0x5678 after the next cmpl, then data=0 -> two data cycles with DCx=1 and DATAx=0x1234 then 0x5678 at the WRx rising edges. No further WRx pulses.
- cmd=1 and data=1 together, data_in=0x002A -> a command cycle is performed (DCx=0).
- data held high for 3 cmpl pulses, data_in constant 0xABCD -> 3 write cycles spaced exactly 5 clocks apart. RDx stays 1 throughout.
- nres pulsed low during WR_LOW -> WRx and CSx return to 1 asynchronously and RESx=0. No cmpl pulse occurs, and the init sequence restarts.
